// File: rtl/entry_pkg.sv
// Shared types and helpers for the lock entry front end.
package entry_pkg;

  typedef enum logic {REL, PRS} state_t;

  localparam int DEFAULT_DW  = 4;
  localparam int MAX_DW      = 32;
  localparam int MAX_CODE_W  = 256;

  // Extract digit number idx (width dw) from a packed code, digit 0 in the LSBs.
  function automatic logic [MAX_DW-1:0] code_digit(input logic [MAX_CODE_W-1:0] code,
                                                   input int idx,
                                                   input int dw);
    logic [MAX_CODE_W-1:0] shifted;
    shifted = code >> (idx * dw);
    return shifted[MAX_DW-1:0] & ((MAX_DW'(1) << dw) - MAX_DW'(1));
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with a selectable reset value.
module sync2 #(
  parameter int         W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/entry_frontend.sv
// Debounced ENTER pulse generator and code-digit comparator for the lock FSM.
module entry_frontend
  import entry_pkg::*;
#(
  parameter int                    DEBOUNCE_CYCLES = 500000,
  parameter int                    DW              = DEFAULT_DW,
  parameter int                    NDIGITS         = 4,
  parameter logic [DW*NDIGITS-1:0] CODE            = 16'h3142
) (
  input  logic                       clk,
  input  logic                       RESETN,
  input  logic                       key_n,
  input  logic [DW-1:0]              sw_digit,
  input  logic                       seq_clr,
  output logic                       ENTER,
  output logic                       MATCH,
  output logic [$clog2(NDIGITS)-1:0] digit_idx
);

  localparam int IW = $clog2(NDIGITS);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          key_sync;
  logic [DW-1:0] sw_sync;
  logic          pressed_s;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_stable_q, btn_stable_d;
  state_t        state_q, state_d;
  logic          enter_q, enter_d;
  logic          match_q, match_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] expected_digit;

  sync2 #(.W(1), .RST_VAL(1'b1)) u_key_sync (
    .clk   (clk),
    .rst_n (RESETN),
    .d_i   (key_n),
    .q_o   (key_sync)
  );

  sync2 #(.W(DW), .RST_VAL('0)) u_sw_sync (
    .clk   (clk),
    .rst_n (RESETN),
    .d_i   (sw_digit),
    .q_o   (sw_sync)
  );

  assign pressed_s = ~key_sync;

  // Accept a level change only after it has held for DEBOUNCE_CYCLES samples.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    cnt_d        = '0;
    btn_stable_d = btn_stable_q;
    if (pressed_s != btn_stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        btn_stable_d = pressed_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Press/release FSM: pulse ENTER once on each accepted press.
  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    case (state_q)
      REL: if (btn_stable_q) begin
        state_d = PRS;
        enter_d = 1'b1;
      end
      PRS: if (!btn_stable_q) state_d = REL;
      default: state_d = REL;
    endcase
  end

  // Compare the synchronized digit on each press and advance the position.
  always_comb begin
    expected_digit = DW'(code_digit(MAX_CODE_W'(CODE), 32'(idx_q), DW));
    match_d        = match_q;
    idx_d          = idx_q;
    if (enter_d) begin
      match_d = (sw_sync == expected_digit);
      idx_d   = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    // A restart from the FSM overrides the advance of a coincident press.
    if (seq_clr) idx_d = '0;
  end

  // State registers for debounce, FSM and match/index outputs.
  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q        <= '0;
      btn_stable_q <= 1'b0;
      state_q      <= REL;
      enter_q      <= 1'b0;
      match_q      <= 1'b0;
      idx_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      cnt_q        <= cnt_d;
      btn_stable_q <= btn_stable_d;
      state_q      <= state_d;
      enter_q      <= enter_d;
      match_q      <= match_d;
      idx_q        <= idx_d;
    end
  end

  assign ENTER     = enter_q;
  assign MATCH     = match_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_entry_frontend.sv
// Self-checking bench for entry_frontend with a behavioural reference model.
module tb_entry_frontend;

  localparam int DEB   = 4;
  localparam int NDIG  = 4;
  localparam int LAT   = 7;

  logic       clk;
  logic       RESETN;
  logic       key_n;
  logic [3:0] sw_digit;
  logic       seq_clr;
  logic       ENTER;
  logic       MATCH;
  logic [1:0] digit_idx;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  // Code 16'h3142 read digit by digit from the LSB end.
  int code_dig [NDIG] = '{2, 4, 1, 3};

  entry_frontend #(
    .DEBOUNCE_CYCLES (DEB),
    .DW              (4),
    .NDIGITS         (NDIG),
    .CODE            (16'h3142)
  ) dut (
    .clk       (clk),
    .RESETN    (RESETN),
    .key_n     (key_n),
    .sw_digit  (sw_digit),
    .seq_clr   (seq_clr),
    .ENTER     (ENTER),
    .MATCH     (MATCH),
    .digit_idx (digit_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The button is seen two clocks late; a new level is accepted once the last
  // DEB seen samples all disagree with the accepted level; ENTER follows one
  // clock after the accepted level rises.
  bit m_k1, m_k2;
  int m_s1, m_s2;
  bit pq[$];
  bit m_stable, m_stable_dly, m_enter, m_match;
  int m_idx;

  always @(posedge clk or negedge RESETN) begin : model
    bit p, en, all_diff;
    if (!RESETN) begin
      m_k1 = 1; m_k2 = 1; m_s1 = 0; m_s2 = 0;
      pq.delete();
      m_stable = 0; m_stable_dly = 0; m_enter = 0; m_match = 0; m_idx = 0;
    end else begin
      p  = !m_k2;
      en = m_stable && !m_stable_dly;
      m_stable_dly = m_stable;
      m_enter = en;
      if (en) begin
        m_match = (m_s2 == code_dig[m_idx]);
        m_idx   = (m_idx + 1) % NDIG;
      end
      if (seq_clr) m_idx = 0;
      pq.push_back(p);
      if (pq.size() > DEB) void'(pq.pop_front());
      if (pq.size() == DEB) begin
        all_diff = 1;
        foreach (pq[i]) if (pq[i] == m_stable) all_diff = 0;
        if (all_diff) m_stable = !m_stable;
      end
      m_k2 = m_k1; m_k1 = key_n;
      m_s2 = m_s1; m_s1 = int'(sw_digit);
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    check("enter", 32'(ENTER), 32'(m_enter));
    check("match", 32'(MATCH), 32'(m_match));
    check("idx",   32'(digit_idx), 32'(m_idx));
    if (ENTER) pulses++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Counts clock edges until ENTER is seen; 40 means it never came.
  task automatic wait_enter(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ENTER) break;
    end
  endtask

  task automatic press(input logic [3:0] sw, input int hold, input logic exp_match,
                       input int exp_idx, input string tag);
    int n, p0;
    p0 = pulses;
    sw_digit = sw;
    key_n = 1'b0;
    wait_enter(n);
    check({tag, "_lat"}, n, LAT);
    check({tag, "_match"}, 32'(MATCH), 32'(exp_match));
    check({tag, "_idx"}, 32'(digit_idx), exp_idx);
    repeat (hold) @(posedge clk);
    #2 key_n = 1'b1;
    tick(12);
    check({tag, "_pulses"}, pulses - p0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0, hold;
    RESETN = 1'b0; key_n = 1'b1; sw_digit = 4'd0; seq_clr = 1'b0;
    #1;
    check("rst_enter", 32'(ENTER), 0);
    check("rst_match", 32'(MATCH), 0);
    check("rst_idx",   32'(digit_idx), 0);
    repeat (3) @(posedge clk);
    #2 RESETN = 1'b1;
    tick(3);

    // Clean press, held 20 cycles.
    press(4'd2, 20, 1'b1, 1, "clean");

    // Bouncy press: four 2-cycle phases, then steady low.
    p0 = pulses;
    sw_digit = 4'd4;
    for (int i = 0; i < 4; i++) begin
      key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    key_n = 1'b0;
    wait_enter(n);
    check("bounce_lat", n, LAT);
    check("bounce_match", 32'(MATCH), 1);
    check("bounce_idx", 32'(digit_idx), 2);
    repeat (10) @(posedge clk);
    #2 key_n = 1'b1;
    tick(12);
    check("bounce_pulses", pulses - p0, 1);

    // Remainder of the full sequence, ending with the wrap.
    press(4'd1, 5, 1'b1, 3, "seq3");
    press(4'd3, 5, 1'b1, 0, "seq4");

    // Wrong digit, then recovery; the last press is held 50 cycles.
    press(4'd2, 5,  1'b1, 1, "wd0");
    press(4'd5, 5,  1'b0, 2, "wd1");
    press(4'd1, 50, 1'b1, 3, "hold");

    // seq_clr coincident with the accepted press.
    sw_digit = 4'd3;
    key_n = 1'b0;
    tick(LAT - 1);
    seq_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("clr_enter", 32'(ENTER), 1);
    check("clr_match", 32'(MATCH), 1);
    check("clr_idx",   32'(digit_idx), 0);
    @(posedge clk);
    #2 seq_clr = 1'b0;
    key_n = 1'b1;
    tick(12);

    // Asynchronous reset mid-debounce with outputs non-zero.
    press(4'd2, 5, 1'b1, 1, "pre_rst");
    key_n = 1'b0;
    tick(4);
    #1 RESETN = 1'b0;
    #1;
    check("arst_enter", 32'(ENTER), 0);
    check("arst_match", 32'(MATCH), 0);
    check("arst_idx",   32'(digit_idx), 0);
    tick(2);
    RESETN = 1'b1;
    wait_enter(n);
    check("post_rst_lat", n, LAT);
    check("post_rst_idx", 32'(digit_idx), 1);
    @(posedge clk);
    #2 key_n = 1'b1;
    tick(12);

    // Randomized stimulus checked by the model.
    p0 = pulses;
    for (int it = 0; it < 250; it++) begin
      key_n = 1'($urandom_range(0, 1));
      sw_digit = ($urandom_range(0, 1) == 1) ? 4'(code_dig[m_idx]) : 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 9);
      repeat (hold) begin
        seq_clr = ($urandom_range(0, 7) == 0);
        @(posedge clk);
        #2;
      end
    end
    seq_clr = 1'b0;
    key_n = 1'b1;
    tick(12);
    check("rand_pulses_seen", 32'(pulses > p0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
